bp_cfg_boot_sequencer: RTL and testbench
========================================

Name: bp_cfg_boot_sequencer

Overview:
- Boot-time configuration controller for a cc_x_dim_p x cc_y_dim_p core array.
- After start, it walks every core tile and issues a fixed sequence of config-register writes over a valid/ready link with credit-based flow control.
- It drains outstanding credits, then releases every core from freeze and signals done.
- It sits between the host/IO complex and the per-tile config links; it is the only master of tile config during boot.

Parameters:
cc_x_dim_p, 1, core columns
cc_y_dim_p, 1, core rows
ic_y_dim_p, 1, row offset added to core y coordinate for cord
max_credits_p, 16, outstanding config writes allowed (1..16)
cfg_addr_width_p, 16, config address width
cfg_data_width_p, 32, config data width
core_id_width_p, `BSG_SAFE_CLOG2(cc_x_dim_p*cc_y_dim_p), core index width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, synchronous, active-low
start_i  in  1  begin sequence; sampled only in IDLE
did_i  in  8  domain id written to every core; static during sequence
icache_mode_i  in  2  icache mode value; static
cce_mode_i  in  2  cce mode value; static
v_o  out  1  config write valid
ready_i  in  1  link accepts write when v_o&ready_i
dst_core_o  out  core_id_width_p  destination core index
addr_o  out  cfg_addr_width_p  config register address
data_o  out  cfg_data_width_p  write data, zero-extended
credit_return_i  in  1  one write retired
busy_o  out  1  not IDLE and not DONE
done_o  out  1  sequence complete, sticky until reset
err_o  out  1  sticky: credit returned with counter at 0

Behaviour:
- Reset (reset_n_i=0 at posedge): state=IDLE, all counters 0; v_o, busy_o, done_o, err_o = 0. Reset mid-sequence aborts immediately with no further writes.
- States: IDLE -> CFG -> DRAIN0 -> UNFREEZE -> DRAIN1 -> DONE.
- IDLE: on start_i=1, go to CFG with core x=0, y=0, reg_idx=0.
- CFG: per core, five writes in order:
  - reg_idx 0: freeze_addr, data 1
  - reg_idx 1: did_addr, did_i
  - reg_idx 2: cord_addr, {y+ic_y_dim_p in [15:8], x in [7:0]}
  - reg_idx 3: icache_mode_addr, icache_mode_i
  - reg_idx 4: cce_mode_addr, cce_mode_i
  - Core order is x inner, y outer. dst_core_o = y*cc_x_dim_p + x, maintained as an incrementing counter with no multiplier.
  - After reg_idx 4 of the last core is accepted, go to DRAIN0.
- DRAIN0: v_o=0. Wait until credit count == 0, then go to UNFREEZE with core 0.
- UNFREEZE: one write per core (freeze_addr, data 0), same core order. After the last core is accepted, go to DRAIN1.
- DRAIN1: wait until credit count == 0, then go to DONE.
- DONE: done_o=1; start_i is ignored; stays until reset.
- Handshake:
  - v_o is asserted in CFG/UNFREEZE only when credits < max_credits_p.
  - Once v_o=1, v_o and the payload stay stable until ready_i=1.
  - Advance occurs only on v_o&ready_i. There is zero bubble between back-to-back accepted writes.
- Credit counter, width clog2(max_credits_p+1):
  - +1 on accept, -1 on credit_return_i.
  - Simultaneous accept and return: count unchanged.
  - Return at count 0: count stays 0 and err_o is set sticky.
  - Counter never exceeds max_credits_p.
- Total writes = 6 * cc_x_dim_p * cc_y_dim_p.
- Outputs are registered-state driven; ready_i does not combinationally affect v_o.

Decomposition:
- Shared package bp_cfg_boot_pkg:
  - state enum bp_cfg_boot_state_e
  - address constants freeze=0x0000, did=0x0004, cord=0x0008, icache_mode=0x000C, cce_mode=0x0010
  - register-sequence length constant = 5
- Sub-module bp_cfg_credit_counter: up/down counter with max/zero flags and underflow error output. Reused for other credit-managed links.

Test Plan:
- 2x1 array, ic_y_dim_p=1, ready_i=1, credit returned 2 cycles after each accept:
  - 12 writes total.
  - Core 1 cord data = 0x0101.
  - Last 2 writes are freeze=0 to cores 0 and 1.
  - done_o rises after the final credit returns.
- 1x1, ready_i toggling 0/1 every cycle:
  - v_o never drops, and payload never changes, while ready_i=0.
  - Exactly 6 accepts.
- max_credits_p=2, credits withheld:
  - v_o deasserts after 2 accepts.
  - Return 1 credit -> exactly 1 more accept.
- Accept and credit_return_i in the same cycle at count 2 -> count stays 2, and the next v_o is gated correctly.
- Assert reset_n_i=0 for one cycle in CFG after 3 accepts:
  - Next cycle v_o=0, busy_o=0, state IDLE.
  - A new start_i replays from core 0, reg_idx 0.
- credit_return_i pulse in IDLE -> err_o=1 and stays 1; the sequence still completes normally with done_o=1.

Source files
------------

// File: rtl/bp_cfg_boot_pkg.sv
// Shared state encoding, config register map and sizing helpers for the
// boot-time tile configuration sequencer.
package bp_cfg_boot_pkg;

    localparam logic [2:0] boot_idle_lp     = 3'd0;
    localparam logic [2:0] boot_cfg_lp      = 3'd1;
    localparam logic [2:0] boot_drain0_lp   = 3'd2;
    localparam logic [2:0] boot_unfreeze_lp = 3'd3;
    localparam logic [2:0] boot_drain1_lp   = 3'd4;
    localparam logic [2:0] boot_done_lp     = 3'd5;

    typedef enum logic [2:0] {
        e_boot_idle     = boot_idle_lp,
        e_boot_cfg      = boot_cfg_lp,
        e_boot_drain0   = boot_drain0_lp,
        e_boot_unfreeze = boot_unfreeze_lp,
        e_boot_drain1   = boot_drain1_lp,
        e_boot_done     = boot_done_lp
    } bp_cfg_boot_state_e;

    localparam logic [15:0] cfg_freeze_addr_lp      = 16'h0000;
    localparam logic [15:0] cfg_did_addr_lp         = 16'h0004;
    localparam logic [15:0] cfg_cord_addr_lp        = 16'h0008;
    localparam logic [15:0] cfg_icache_mode_addr_lp = 16'h000C;
    localparam logic [15:0] cfg_cce_mode_addr_lp    = 16'h0010;

    localparam int unsigned cfg_seq_len_lp = 5;

    // Index widths never collapse to zero, even for a single-entry range.
    function automatic int safe_clog2(input int unsigned n);
        safe_clog2 = (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [15:0] cfg_reg_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    cfg_reg_addr = cfg_freeze_addr_lp;
            3'd1:    cfg_reg_addr = cfg_did_addr_lp;
            3'd2:    cfg_reg_addr = cfg_cord_addr_lp;
            3'd3:    cfg_reg_addr = cfg_icache_mode_addr_lp;
            default: cfg_reg_addr = cfg_cce_mode_addr_lp;
        endcase
    endfunction

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Up/down credit counter for a credit-managed link: saturates at max_credits_p,
// holds at zero on an unmatched return and flags that underflow stickily.
module bp_cfg_credit_counter #(
    parameter int max_credits_p = 16,
    parameter int count_width_p = $clog2(max_credits_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     up_i,
    input  logic                     down_i,
    output logic [count_width_p-1:0] count_o,
    output logic                     zero_o,
    output logic                     max_o,
    output logic                     err_o
);

    localparam logic [count_width_p-1:0] max_lp = count_width_p'(max_credits_p);

    logic [count_width_p-1:0] count_q, count_d;
    logic                     err_q, err_d;

    // A return paired with an accept in the same cycle cancels out.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (up_i && !down_i) begin
            if (count_q != max_lp) begin
                count_d = count_q + count_width_p'(1);
            end
        end else if (down_i && !up_i) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q - count_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    assign max_o   = (count_q == max_lp);
    assign err_o   = err_q;

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time configuration master: walks every core tile, writes its config
// registers over a credited valid/ready link, drains, then unfreezes all cores.
module bp_cfg_boot_sequencer
    import bp_cfg_boot_pkg::*;
#(
    parameter int cc_x_dim_p       = 1,
    parameter int cc_y_dim_p       = 1,
    parameter int ic_y_dim_p       = 1,
    parameter int max_credits_p    = 16,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int core_id_width_p  = safe_clog2(cc_x_dim_p * cc_y_dim_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 start_i,
    input  logic [7:0]                           did_i,
    input  logic [1:0]                           icache_mode_i,
    input  logic [1:0]                           cce_mode_i,
    output logic                                 v_o,
    input  logic                                 ready_i,
    output logic [core_id_width_p-1:0]           dst_core_o,
    output logic [cfg_addr_width_p-1:0]          addr_o,
    output logic [cfg_data_width_p-1:0]          data_o,
    input  logic                                 credit_return_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o,
    output logic [2:0]                           dbg_state_o,
    output logic [$clog2(max_credits_p+1)-1:0]   dbg_credits_o
);

    localparam int x_width_lp      = safe_clog2(cc_x_dim_p);
    localparam int y_width_lp      = safe_clog2(cc_y_dim_p);
    localparam int credit_width_lp = $clog2(max_credits_p + 1);

    localparam logic [x_width_lp-1:0] x_last_lp   = x_width_lp'(cc_x_dim_p - 1);
    localparam logic [y_width_lp-1:0] y_last_lp   = y_width_lp'(cc_y_dim_p - 1);
    localparam logic [2:0]            reg_last_lp = 3'(cfg_seq_len_lp - 1);

    bp_cfg_boot_state_e         state_q, state_d;
    logic [x_width_lp-1:0]      x_q, x_d, x_next;
    logic [y_width_lp-1:0]      y_q, y_d, y_next;
    logic [core_id_width_p-1:0] core_q, core_d;
    logic [2:0]                 reg_idx_q, reg_idx_d;

    logic [credit_width_lp-1:0] credit_count;
    logic                       credit_zero;
    logic                       credit_full;
    logic                       credit_err;

    logic                       issuing;
    logic                       accept;
    logic                       last_core;
    logic [7:0]                 cord_x;
    logic [7:0]                 cord_y;

    // Link handshake: v_o depends only on registered state and the credit
    // count, so it never reacts to ready_i within a cycle. Once raised it stays
    // up with a stable payload until v_o & ready_i, which is the only event that
    // advances the walk; credits only fall while waiting, so nothing retracts it.
    assign issuing   = (state_q == e_boot_cfg) || (state_q == e_boot_unfreeze);
    assign v_o       = issuing && !credit_full;
    assign accept    = v_o && ready_i;
    assign last_core = (x_q == x_last_lp) && (y_q == y_last_lp);

    bp_cfg_credit_counter #(
        .max_credits_p (max_credits_p),
        .count_width_p (credit_width_lp)
    ) credit_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .up_i      (accept),
        .down_i    (credit_return_i),
        .count_o   (credit_count),
        .zero_o    (credit_zero),
        .max_o     (credit_full),
        .err_o     (credit_err)
    );

    // Column index runs fastest; the linear core id is a separate counter.
    always_comb begin
        x_next = x_q + x_width_lp'(1);
        y_next = y_q;
        if (x_q == x_last_lp) begin
            x_next = '0;
            y_next = y_q + y_width_lp'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        core_d    = core_q;
        reg_idx_d = reg_idx_q;
        case (state_q)
            e_boot_idle: begin
                if (start_i) begin
                    state_d   = e_boot_cfg;
                    x_d       = '0;
                    y_d       = '0;
                    core_d    = '0;
                    reg_idx_d = '0;
                end
            end
            e_boot_cfg: begin
                if (accept) begin
                    if (reg_idx_q == reg_last_lp) begin
                        reg_idx_d = '0;
                        if (last_core) begin
                            state_d = e_boot_drain0;
                            x_d     = '0;
                            y_d     = '0;
                            core_d  = '0;
                        end else begin
                            x_d    = x_next;
                            y_d    = y_next;
                            core_d = core_q + core_id_width_p'(1);
                        end
                    end else begin
                        reg_idx_d = reg_idx_q + 3'd1;
                    end
                end
            end
            e_boot_drain0: begin
                if (credit_zero) begin
                    state_d = e_boot_unfreeze;
                end
            end
            e_boot_unfreeze: begin
                if (accept) begin
                    if (last_core) begin
                        state_d = e_boot_drain1;
                        x_d     = '0;
                        y_d     = '0;
                        core_d  = '0;
                    end else begin
                        x_d    = x_next;
                        y_d    = y_next;
                        core_d = core_q + core_id_width_p'(1);
                    end
                end
            end
            e_boot_drain1: begin
                if (credit_zero) begin
                    state_d = e_boot_done;
                end
            end
            e_boot_done: begin
                state_d = e_boot_done;
            end
            default: begin
                state_d = e_boot_idle;
            end
        endcase
    end

    assign cord_x = 8'(x_q);
    assign cord_y = 8'(y_q) + 8'(ic_y_dim_p);

    always_comb begin
        dst_core_o = core_q;
        addr_o     = '0;
        data_o     = '0;
        if (state_q == e_boot_cfg) begin
            addr_o = cfg_addr_width_p'(cfg_reg_addr(reg_idx_q));
            case (reg_idx_q)
                3'd0:    data_o = cfg_data_width_p'(1);
                3'd1:    data_o = cfg_data_width_p'(did_i);
                3'd2:    data_o = cfg_data_width_p'({cord_y, cord_x});
                3'd3:    data_o = cfg_data_width_p'(icache_mode_i);
                default: data_o = cfg_data_width_p'(cce_mode_i);
            endcase
        end else if (state_q == e_boot_unfreeze) begin
            addr_o = cfg_addr_width_p'(cfg_freeze_addr_lp);
            data_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= e_boot_idle;
            x_q       <= '0;
            y_q       <= '0;
            core_q    <= '0;
            reg_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            core_q    <= core_d;
            reg_idx_q <= reg_idx_d;
        end
    end

    assign busy_o        = (state_q != e_boot_idle) && (state_q != e_boot_done);
    assign done_o        = (state_q == e_boot_done);
    assign err_o         = credit_err;
    assign dbg_state_o   = state_q;
    assign dbg_credits_o = credit_count;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Self-checking bench for bp_cfg_boot_sequencer on a 3x2 array with two credits:
// a per-cycle monitor compares the link against a write-list scoreboard.
module tb_bp_cfg_boot_sequencer;

  localparam int X          = 3;
  localparam int Y          = 2;
  localparam int IC         = 1;
  localparam int MAXC       = 2;
  localparam int AW         = 16;
  localparam int DW         = 32;
  localparam int N          = X * Y;
  localparam int CFG_WRITES = 5 * N;
  localparam int TOTAL      = 6 * N;
  localparam int CW         = 3;
  localparam int CRW        = 2;
  localparam int W          = CW + AW + DW;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic           clk;
  logic           reset_n_i;
  logic           start_i;
  logic [7:0]     did_i;
  logic [1:0]     icache_mode_i;
  logic [1:0]     cce_mode_i;
  logic           v_o;
  logic           ready_i;
  logic [CW-1:0]  dst_core_o;
  logic [AW-1:0]  addr_o;
  logic [DW-1:0]  data_o;
  logic           credit_return_i;
  logic           busy_o;
  logic           done_o;
  logic           err_o;
  logic [2:0]     dbg_state_o;
  logic [CRW-1:0] dbg_credits_o;

  bp_cfg_boot_sequencer #(
    .cc_x_dim_p       (X),
    .cc_y_dim_p       (Y),
    .ic_y_dim_p       (IC),
    .max_credits_p    (MAXC),
    .cfg_addr_width_p (AW),
    .cfg_data_width_p (DW)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n_i),
    .start_i         (start_i),
    .did_i           (did_i),
    .icache_mode_i   (icache_mode_i),
    .cce_mode_i      (cce_mode_i),
    .v_o             (v_o),
    .ready_i         (ready_i),
    .dst_core_o      (dst_core_o),
    .addr_o          (addr_o),
    .data_o          (data_o),
    .credit_return_i (credit_return_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .dbg_state_o     (dbg_state_o),
    .dbg_credits_o   (dbg_credits_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  int           ret_due[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           accepts = 0;
  int           out_model = 0;
  logic         err_model = 1'b0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_payload = '0;
  logic [15:0]  core1_cord = 16'hffff;
  int           ready_mode = 0;
  int           ret_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int core, input int addr, input int data);
    logic [W-1:0] e;
    e = {CW'(core), AW'(addr), DW'(data)};
    exp_q.push_back(e);
  endtask

  // Full write list of one boot: five config writes per core, then one unfreeze each.
  task automatic build_exp();
    exp_q.delete();
    for (int y = 0; y < Y; y++) begin
      for (int x = 0; x < X; x++) begin
        push_exp(y * X + x, 'h0000, 1);
        push_exp(y * X + x, 'h0004, int'(did_i));
        push_exp(y * X + x, 'h0008, ((y + IC) << 8) | x);
        push_exp(y * X + x, 'h000C, int'(icache_mode_i));
        push_exp(y * X + x, 'h0010, int'(cce_mode_i));
      end
    end
    for (int c = 0; c < N; c++) push_exp(c, 'h0000, 0);
  endtask

  task automatic reset_model();
    exp_q.delete();
    ret_due.delete();
    accepts    = 0;
    out_model  = 0;
    err_model  = 1'b0;
    hold_prev  = 1'b0;
    core1_cord = 16'hffff;
  endtask

  // Per-cycle monitor, run at the falling edge with this cycle's inputs.
  task automatic sample();
    logic [W-1:0] pay;
    logic         acc;
    pay = {dst_core_o, addr_o, data_o};
    acc = v_o && ready_i;
    if (hold_prev) begin
      check("hold_valid", v_o, 1);
      check("hold_payload", pay, prev_payload);
    end
    if (v_o) begin
      if (exp_q.size() == 0) check("spurious_valid", v_o, 0);
      else check("payload", pay, exp_q[0]);
    end
    if (accepts >= 1 && accepts < CFG_WRITES) begin
      check("cfg_gate", v_o, out_model < MAXC);
      check("cfg_busy", busy_o, 1);
    end else if (accepts == CFG_WRITES && out_model > 0) begin
      check("drain0_quiet", v_o, 0);
    end else if (accepts > CFG_WRITES && accepts < TOTAL) begin
      check("unfreeze_gate", v_o, out_model < MAXC);
      check("unfreeze_busy", busy_o, 1);
    end
    if (exp_q.size() != 0 || out_model != 0) check("done_early", done_o, 0);
    check("credits", dbg_credits_o, out_model);
    check("err", err_o, err_model);

    hold_prev    = v_o && !ready_i;
    prev_payload = pay;
    if (acc) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (dst_core_o == CW'(1) && addr_o == 16'h0008) core1_cord = data_o[15:0];
      accepts++;
      out_model++;
      if (ret_mode == 1) ret_due.push_back(cyc + 2);
      else if (ret_mode == 2) ret_due.push_back(cyc + int'($urandom_range(1, 4)));
    end
    if (credit_return_i) begin
      if (out_model > 0) out_model--;
      else err_model = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_next();
    case (ready_mode)
      0:       ready_i = 1'b1;
      1:       ready_i = !ready_i;
      default: ready_i = ($urandom_range(0, 3) != 0);
    endcase
    credit_return_i = 1'b0;
    if (ret_mode != 0) begin
      for (int i = 0; i < ret_due.size(); i++) begin
        if (ret_due[i] <= cyc) begin
          credit_return_i = 1'b1;
          ret_due.delete(i);
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    drive_next();
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    reset_model();
  endtask

  task automatic start_seq();
    did_i         = 8'($urandom_range(0, 255));
    icache_mode_i = 2'($urandom_range(0, 3));
    cce_mode_i    = 2'($urandom_range(0, 3));
    build_exp();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, done_o, 1);
    check({tag, "_accepts"}, accepts, TOTAL);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_state"}, dbg_state_o, ST_DONE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n_i       = 1'b0;
    start_i         = 1'b0;
    did_i           = 8'h00;
    icache_mode_i   = 2'd0;
    cce_mode_i      = 2'd0;
    ready_i         = 1'b1;
    credit_return_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_v", v_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_state", dbg_state_o, ST_IDLE);
    check("rst_credits", dbg_credits_o, 0);
    reset_n_i = 1'b1;
    repeat (2) tick();

    // Credits withheld: two accepts fill the window, one return frees one slot.
    ready_mode = 0;
    ret_mode   = 0;
    start_seq();
    for (int i = 0; i < 20 && accepts < 2; i++) tick();
    check("withhold_accepts", accepts, 2);
    check("withhold_gate", v_o, 0);
    repeat (3) tick();
    check("withhold_still", accepts, 2);
    credit_return_i = 1'b1;
    tick();
    repeat (8) tick();
    check("one_more_accept", accepts, 3);
    check("full_again", v_o, 0);

    // Reset in the middle of CFG aborts the walk.
    do_reset();
    check("midrst_v", v_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_state", dbg_state_o, ST_IDLE);
    check("midrst_credits", dbg_credits_o, 0);

    // Unmatched credit in IDLE, then a full boot with random ready/credit timing.
    credit_return_i = 1'b1;
    tick();
    check("idle_err", err_o, 1);
    ready_mode = 2;
    ret_mode   = 2;
    start_seq();
    run_to_done(3000, "random");
    check("random_err_sticky", err_o, 1);

    // Ready toggling every cycle, credits back two cycles after each accept.
    do_reset();
    ready_mode = 1;
    ret_mode   = 1;
    ready_i    = 1'b0;
    start_seq();
    run_to_done(3000, "toggle");
    check("toggle_core1_cord", core1_cord, 16'h0101);
    check("toggle_err", err_o, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    check("done_ignores_start", dbg_state_o, ST_DONE);
    check("done_sticky", done_o, 1);
    check("done_no_writes", accepts, TOTAL);

    // Ready held high with fixed two-cycle credit returns.
    do_reset();
    ready_mode = 0;
    ret_mode   = 1;
    start_seq();
    run_to_done(3000, "steady");
    check("steady_core1_cord", core1_cord, 16'h0101);
    check("steady_err", err_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
